v_issue_queue: RTL and testbench

- Instruction issue buffer between the scalar base processor and the vector coprocessor top.
- Accepts 32-bit vector instructions from the base core through a valid/ready handshake and buffers them in a small FIFO.
- Presents one instruction at a time, held stable on the coprocessor's instruction input, until the executing unit signals completion.
- Filters out non-vector opcodes and retires vector-config instructions in a single cycle.

---
 rtl/v_issue_queue.sv | 124 ++++++++++++
 tb/tb_v_issue_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/v_issue_queue.sv
// Vector instruction issue buffer: filters base-core instructions into a small FIFO and holds one on out_instr until it completes.
// Optional forced retire on a stuck unit: define V_ISSUE_TIMEOUT_EN (TIMEOUT cycles, sticky timeout_err).
module v_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_valid,
    input  logic [31:0]            in_instr,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   unit_done,
    output logic [31:0]            out_instr,
    output logic                   out_valid,
    output logic                   out_is_cfg,
    output logic                   retire,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   timeout_err
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        cfg;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic {IDLE, EXEC} state_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    state_t      state;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [6:0]  opcode;
    logic        full, empty, accepted, is_cfg;
    logic        push, pop, done_now, timeout_hit;

    assign opcode   = in_instr[6:0];
    assign accepted = (opcode == 7'b1010111) || (opcode == 7'b0000111) || (opcode == 7'b0100111);
    assign is_cfg   = (opcode == 7'b1010111) && (in_instr[14:12] == 3'b111);

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign in_ready = !full;
    assign busy     = !empty || (state == EXEC);

    assign push     = in_valid && !full && accepted;
    assign done_now = (state == EXEC) && (out_is_cfg || unit_done || timeout_hit);
    assign pop      = !empty && ((state == IDLE) || done_now);
    // A flushed instruction never counts as retired, even if its unit finishes that cycle.
    assign retire   = done_now && !flush;
    assign head     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{cfg: is_cfg, instr: in_instr};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= IDLE;
            out_instr  <= '0;
            out_is_cfg <= 1'b0;
            out_valid  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= IDLE;
            out_instr  <= '0;
            out_is_cfg <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                out_instr  <= head.instr;
                out_is_cfg <= head.cfg;
                out_valid  <= 1'b1;
                state      <= EXEC;
            end else if (done_now) begin
                out_instr  <= '0;
                out_is_cfg <= 1'b0;
                out_valid  <= 1'b0;
                state      <= IDLE;
            end
        end
    end

`ifdef V_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr;
    logic          tmo_err_q;

    // tmr counts completed EXEC cycles, so the TIMEOUT-th cycle sees TIMEOUT-1.
    assign timeout_hit = !out_is_cfg && !unit_done && (tmr == TW'(TIMEOUT - 1));
    assign timeout_err = tmo_err_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmr       <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (pop || flush)
                tmr <= '0;
            else if (state == EXEC)
                tmr <= tmr + 1'b1;
            if ((state == EXEC) && timeout_hit && !flush)
                tmo_err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_v_issue_queue.sv
// Directed bench for v_issue_queue; retired instructions are checked in order against a scoreboard.
module tb_v_issue_queue;
    logic        clk = 1'b0;
    logic        nrst, in_valid, in_ready, flush, unit_done;
    logic [31:0] in_instr, out_instr;
    logic        out_valid, out_is_cfg, retire, busy, timeout_err;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] instr;
        logic        cfg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] OP_VADD = 32'h0220_8057;
    localparam logic [31:0] OP_VSET = 32'h0C00_7057;
    localparam logic [31:0] OP_ADDI = 32'h0000_0013;
    localparam logic [31:0] OP_REJ  = 32'h0280_8057;
    logic [31:0] ops [5] = '{32'h0220_8057, 32'h0240_8057, 32'h0200_7007,
                             32'h0200_7027, 32'h0260_8057};

    v_issue_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .unit_done(unit_done),
        .out_instr(out_instr), .out_valid(out_valid), .out_is_cfg(out_is_cfg),
        .retire(retire), .busy(busy), .count(count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every retire pulse must match the oldest outstanding expected instruction.
    always @(negedge clk) begin
        if (nrst === 1'b1 && retire === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL retire_unexpected observed=%h expected=none", out_instr);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("retire_instr", out_instr, e.instr);
                chk("retire_cfg", {31'b0, out_is_cfg}, {31'b0, e.cfg});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nrst = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; unit_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", timeout_err, 0);

        // single op, completes on its fifth EXEC cycle
        cyc(); in_valid = 1'b1; in_instr = OP_VADD; sb.push_back('{OP_VADD, 1'b0});
        @(negedge clk); chk("single_ready", in_ready, 1);
        cyc(); in_valid = 1'b0;
        @(negedge clk); chk("single_count", count, 1); chk("single_nobypass", out_valid, 0);
        cyc();
        @(negedge clk);
        chk("single_valid", out_valid, 1); chk("single_instr", out_instr, OP_VADD);
        chk("single_count0", count, 0); chk("single_busy", busy, 1);
        repeat (3) begin
            cyc(); @(negedge clk);
            chk("single_wait_ret", retire, 0); chk("single_wait_vld", out_valid, 1);
        end
        cyc(); unit_done = 1'b1;
        @(negedge clk); chk("single_retire", retire, 1);
        cyc(); unit_done = 1'b0;
        @(negedge clk);
        chk("single_done_vld", out_valid, 0); chk("single_done_instr", out_instr, 0);
        chk("single_done_busy", busy, 0);

        // config retires in its only EXEC cycle without unit_done
        cyc(); in_valid = 1'b1; in_instr = OP_VSET; sb.push_back('{OP_VSET, 1'b1});
        cyc(); in_valid = 1'b0;
        @(negedge clk); chk("cfg_pre_vld", out_valid, 0);
        cyc();
        @(negedge clk);
        chk("cfg_vld", out_valid, 1); chk("cfg_tag", out_is_cfg, 1); chk("cfg_retire", retire, 1);
        cyc();
        @(negedge clk); chk("cfg_post_vld", out_valid, 0); chk("cfg_post_tag", out_is_cfg, 0);

        // fill while the first op is blocked, then drain back-to-back
        for (int i = 0; i < 5; i++) begin
            cyc(); in_valid = 1'b1; in_instr = ops[i]; sb.push_back('{ops[i], 1'b0});
            @(negedge clk); chk("fill_ready", in_ready, 1);
        end
        cyc(); in_instr = OP_REJ;
        @(negedge clk);
        chk("fill_count", count, 4); chk("fill_full", in_ready, 0); chk("fill_head", out_instr, ops[0]);
        cyc(); in_valid = 1'b0;
        @(negedge clk); chk("fill_reject", count, 4);
        for (int i = 0; i < 5; i++) begin
            cyc(); unit_done = 1'b1;
            @(negedge clk);
            chk("drain_retire", retire, 1); chk("drain_vld", out_valid, 1);
            chk("drain_count", count, 32'(4 - i));
        end
        cyc(); unit_done = 1'b0;
        @(negedge clk); chk("drain_vld_end", out_valid, 0); chk("drain_busy", busy, 0);

        // non-vector opcode is consumed but dropped
        cyc(); in_valid = 1'b1; in_instr = OP_ADDI;
        @(negedge clk); chk("filt_ready", in_ready, 1);
        cyc(); in_valid = 1'b0;
        @(negedge clk);
        chk("filt_count", count, 0); chk("filt_busy", busy, 0); chk("filt_vld", out_valid, 0);
        cyc(); @(negedge clk); chk("filt_vld2", out_valid, 0);

        // flush beats simultaneous push and completion, and emits no retire
        for (int i = 0; i < 3; i++) begin
            cyc(); in_valid = 1'b1; in_instr = ops[i];
        end
        cyc(); in_valid = 1'b0;
        @(negedge clk); chk("flush_pre_count", count, 2); chk("flush_pre_vld", out_valid, 1);
        cyc(); flush = 1'b1; unit_done = 1'b1; in_valid = 1'b1; in_instr = ops[3];
        @(negedge clk); chk("flush_noretire", retire, 0);
        cyc(); flush = 1'b0; unit_done = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", count, 0); chk("flush_vld", out_valid, 0);
        chk("flush_instr", out_instr, 0); chk("flush_busy", busy, 0);

        // asynchronous reset while an op executes and another waits
        cyc(); in_valid = 1'b1; in_instr = ops[0];
        cyc(); in_instr = ops[1];
        cyc(); in_valid = 1'b0;
        @(negedge clk); chk("arst_pre_vld", out_valid, 1); chk("arst_pre_count", count, 1);
        #1 nrst = 1'b0;
        #1;
        chk("arst_vld", out_valid, 0); chk("arst_instr", out_instr, 0);
        chk("arst_ready", in_ready, 1); chk("arst_count", count, 0);
        cyc(); nrst = 1'b1;
        @(negedge clk); chk("arst_post_vld", out_valid, 0); chk("arst_post_busy", busy, 0);

`ifdef V_ISSUE_TIMEOUT_EN
        cyc(); in_valid = 1'b1; in_instr = ops[1]; sb.push_back('{ops[1], 1'b0});
        cyc(); in_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) n++;
            if (retire) break;
            cyc();
        end
        chk("tmo_cycles", n, 8);
        cyc();
        @(negedge clk); chk("tmo_err", timeout_err, 1); chk("tmo_vld", out_valid, 0);
        repeat (3) cyc();
        @(negedge clk); chk("tmo_sticky", timeout_err, 1);
`else
        cyc(); in_valid = 1'b1; in_instr = ops[1]; sb.push_back('{ops[1], 1'b0});
        cyc(); in_valid = 1'b0;
        n = 0;
        repeat (80) begin
            cyc(); @(negedge clk);
            if (out_valid) n++;
        end
        chk("stall_cycles", n, 80); chk("stall_tmo", timeout_err, 0);
        cyc(); unit_done = 1'b1;
        @(negedge clk); chk("stall_retire", retire, 1);
        cyc(); unit_done = 1'b0;
        @(negedge clk); chk("stall_end_vld", out_valid, 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
